// File: rtl/rv_muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: Funct3 op codes,
// FSM states, decode constants and operand signedness helpers.
package rv_muldiv_pkg;

  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic op_signed_a(input md_op_e op);
    return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_signed_b(input md_op_e op);
    return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/rv_muldiv_step.sv
// One combinational CALC iteration: UNROLL bits of LSB-first shift-add
// multiply or MSB-first restoring divide on magnitude operands.
module rv_muldiv_step
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   rem,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] prod_nxt,
  output logic [XLEN-1:0]   rem_nxt
);

  logic [2*XLEN-1:0] p_s;
  logic [XLEN:0]     r_s;
  logic [XLEN:0]     sum_s;

  // Divide keeps dividend/quotient in prod's low half; multiply keeps {acc, multiplier}.
  always_comb begin
    p_s   = prod;
    r_s   = {1'b0, rem};
    sum_s = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        r_s           = {r_s[XLEN-1:0], p_s[XLEN-1]};
        p_s[XLEN-1:0] = {p_s[XLEN-2:0], 1'b0};
        if (r_s >= {1'b0, opb}) begin
          r_s    = r_s - {1'b0, opb};
          p_s[0] = 1'b1;
        end else begin
          p_s[0] = 1'b0;
        end
      end else begin
        sum_s = {1'b0, p_s[2*XLEN-1:XLEN]} + (p_s[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        p_s   = {sum_s, p_s[XLEN-1:1]};
      end
    end
    prod_nxt = p_s;
    rem_nxt  = r_s[XLEN-1:0];
  end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU; holds the
// pipeline with stall while an M instruction is in flight.
module rv_muldiv_unit
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            is_m_op,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int ITER = XLEN / UNROLL;
  localparam int CW   = $clog2(ITER + 1) + 1;
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_ITER = CW'(ITER);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_r;
  md_op_e            op_r, op_s;
  logic              sign_a_r, sign_b_r, sign_a_s, sign_b_s;
  logic [XLEN-1:0]   opb_r, rem_r, rem_nxt_s;
  logic [XLEN-1:0]   a_abs_s, b_abs_s, special_res_s, final_s;
  logic [XLEN-1:0]   quot_fix_s, rem_fix_s;
  logic [2*XLEN-1:0] prod_r, prod_nxt_s, prod_fix_s;
  logic [CW-1:0]     cnt_r;
  logic              accept_s, div_zero_s, div_ovf_s;

  assign op_s       = md_op_e'(Funct3);
  assign is_m_op    = in_valid && (ALUOp == ALUOP_RTYPE) && (Funct7 == FUNCT7_MEXT);
  assign stall      = is_m_op && (state_r != DONE) && !flush;
  assign accept_s   = is_m_op && !flush && (state_r == IDLE);
  assign done       = (state_r == DONE);
  assign sign_a_s   = op_signed_a(op_s) && SrcA[XLEN-1];
  assign sign_b_s   = op_signed_b(op_s) && SrcB[XLEN-1];
  assign a_abs_s    = sign_a_s ? -SrcA : SrcA;
  assign b_abs_s    = sign_b_s ? -SrcB : SrcB;
  assign div_zero_s = Funct3[2] && (SrcB == '0);
  assign div_ovf_s  = ((op_s == DIV) || (op_s == REM)) && (SrcA == XMIN) && (SrcB == '1);

  rv_muldiv_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
    .is_div   (op_r[2]),
    .prod     (prod_r),
    .rem      (rem_r),
    .opb      (opb_r),
    .prod_nxt (prod_nxt_s),
    .rem_nxt  (rem_nxt_s)
  );

  // Results that bypass iteration: divide by zero and signed overflow.
  always_comb begin
    if (div_ovf_s) begin
      special_res_s = Funct3[1] ? {XLEN{1'b0}} : SrcA;
    end else if (Funct3[1]) begin
      special_res_s = SrcA;
    end else begin
      special_res_s = {XLEN{1'b1}};
    end
  end

  // Sign correction and result selection from the last step's output.
  always_comb begin
    prod_fix_s = (sign_a_r ^ sign_b_r) ? -prod_nxt_s : prod_nxt_s;
    quot_fix_s = (sign_a_r ^ sign_b_r) ? -prod_nxt_s[XLEN-1:0] : prod_nxt_s[XLEN-1:0];
    rem_fix_s  = sign_a_r ? -rem_nxt_s : rem_nxt_s;
    case (op_r)
      MUL:                 final_s = prod_fix_s[XLEN-1:0];
      MULH, MULHSU, MULHU: final_s = prod_fix_s[2*XLEN-1:XLEN];
      DIV, DIVU:           final_s = quot_fix_s;
      REM, REMU:           final_s = rem_fix_s;
      default:             final_s = quot_fix_s;
    endcase
  end

  // Control FSM, operand latches and the iteration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      op_r     <= MUL;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      opb_r    <= '0;
      prod_r   <= '0;
      rem_r    <= '0;
      cnt_r    <= '0;
      result   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r     <= op_s;
            sign_a_r <= sign_a_s;
            sign_b_r <= sign_b_s;
            opb_r    <= b_abs_s;
            prod_r   <= {{XLEN{1'b0}}, a_abs_s};
            rem_r    <= '0;
            cnt_r    <= CNT_ITER;
            if (div_zero_s || div_ovf_s) begin
              state_r <= DONE;
              result  <= special_res_s;
            end else begin
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state_r <= IDLE;
          end else begin
            prod_r <= prod_nxt_s;
            rem_r  <= rem_nxt_s;
            cnt_r  <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r <= DONE;
              result  <= final_s;
            end
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Scoreboard bench for rv_muldiv_unit: expected results and latencies are
// queued when an M op is driven and compared when done pulses.
module tb_rv_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush;
  logic [1:0]  ALUOp;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        is_m_op, stall, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] last_exp = 32'h0;

  rv_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB),
    .is_m_op(is_m_op), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (f)
      3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'h0, b};       return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b};             return p[63:32]; end
      3'd4: return (b == 32'h0) ? 32'hFFFFFFFF : (ovf ? a : 32'(sa / sb));
      3'd5: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      3'd6: return (b == 32'h0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'h0)) return 1;
    if (((f == 3'd4) || (f == 3'd6)) && (a == 32'h80000000) && (b == 32'hFFFFFFFF)) return 1;
    return 33;
  endfunction

  // Drives one M op starting in an IDLE cycle; operands are scrambled mid-CALC.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int cyc, stl, el;
    bit seen;
    logic [31:0] e;
    exp_q.push_back(ref_md(f, a, b));
    lat_q.push_back(ref_lat(f, a, b));
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f; SrcA = a; SrcB = b;
    in_valid = 1'b1; flush = 1'b0;
    #1;
    total++;
    if (is_m_op !== 1'b1) begin bad++; $display("FAIL is_m_op f=%0d: got %b want 1", f, is_m_op); end
    stl = stall ? 1 : 0;
    seen = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin SrcA = ~a; SrcB = a ^ b ^ 32'h5A5A0001; end
      if (stall) stl++;
      if (done) begin seen = 1'b1; cyc = i; break; end
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    total++;
    if (!seen) begin
      bad++; $display("FAIL done_timeout f=%0d a=%h b=%h: no done within 60 cycles", f, a, b);
    end else begin
      last_exp = e;
      total++;
      if (result !== e) begin bad++; $display("FAIL result f=%0d a=%h b=%h: got %h want %h", f, a, b, result, e); end
      total++;
      if (cyc != el) begin bad++; $display("FAIL latency f=%0d: got %0d want %0d", f, cyc, el); end
      total++;
      if (stl != el) begin bad++; $display("FAIL stall_cycles f=%0d: got %0d want %0d", f, stl, el); end
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_width f=%0d: got %b want 0", f, done); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    ALUOp = 2'b00; Funct7 = 7'h0; Funct3 = 3'h0; SrcA = 32'h0; SrcB = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({done, stall, is_m_op} !== 3'b000 || result !== 32'h0) begin
      bad++; $display("FAIL reset_state: got done=%b stall=%b m=%b result=%h want 0", done, stall, is_m_op, result);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    issue(3'd0, 32'd7, 32'hFFFFFFFD);
    issue(3'd1, 32'h80000000, 32'h80000000);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(3'd2, 32'hFFFFFFFF, 32'h00000002);
  endtask

  task automatic test_div();
    issue(3'd4, 32'hFFFFFFF9, 32'd2);
    issue(3'd6, 32'hFFFFFFF9, 32'd2);
    issue(3'd5, 32'd100, 32'd7);
    issue(3'd7, 32'd100, 32'd7);
  endtask

  task automatic test_special();
    issue(3'd5, 32'd5, 32'd0);
    issue(3'd6, 32'd5, 32'd0);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF);
  endtask

  task automatic test_back_to_back();
    logic [2:0] f;
    logic [31:0] a, b;
    for (int k = 0; k < 8; k++) begin
      f = 3'($urandom_range(7));
      a = $urandom;
      b = (k % 3 == 0) ? 32'($urandom_range(3)) : $urandom;
      issue(f, a, b);
    end
  endtask

  task automatic test_flush();
    int pulses;
    logic [31:0] held;
    held = last_exp;
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd4; SrcA = 32'd1000; SrcB = 32'd3;
    in_valid = 1'b1; flush = 1'b0;
    pulses = 0;
    repeat (10) begin @(posedge clk); #1; if (done) pulses++; end
    flush = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL flush_done: got %0d pulses want 0", pulses); end
    total++;
    if (result !== held) begin bad++; $display("FAIL flush_result: got %h want %h", result, held); end
    issue(3'd0, 32'd3, 32'd4);
  endtask

  task automatic test_async_reset();
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd0; SrcA = 32'd5; SrcB = 32'd6;
    in_valid = 1'b1; flush = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1; in_valid = 1'b0;
    #1;
    total++;
    if ({done, stall} !== 2'b00 || result !== 32'h0) begin
      bad++; $display("FAIL async_reset: got done=%b stall=%b result=%h want 0/0/0", done, stall, result);
    end
    last_exp = 32'h0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_non_m();
    int hits;
    hits = 0;
    ALUOp = 2'b10; Funct7 = 7'b0000000; Funct3 = 3'd0; SrcA = 32'd9; SrcB = 32'd9;
    in_valid = 1'b1; flush = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (is_m_op || stall || done) hits++;
      @(posedge clk); #1;
    end
    total++;
    if (hits != 0) begin bad++; $display("FAIL non_m_op: got %0d active cycles want 0", hits); end
    total++;
    if (result !== last_exp) begin bad++; $display("FAIL non_m_result: got %h want %h", result, last_exp); end
    in_valid = 1'b0;
    issue(3'd7, 32'd23, 32'd5);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_non_m();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Parametrised successor to the single-cycle ALU operation decoder for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Decodes ALUOp/Funct7/Funct3 like the ALU decoder, then runs an iterative shift-add multiplier or restoring divider.
- Sits beside the ALU in EX. While an M instruction executes it raises `stall`, so the hazard unit freezes IF/ID/EX. The result is muxed into the EX result path.

Parameters:
- XLEN, 32, operand/result width; must be even and ≥8.
- UNROLL, 1, bits processed per CALC cycle; must divide XLEN.
- ITER (localparam), XLEN/UNROLL, CALC cycle count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  EX stage holds a valid instruction.
- flush  in  1  kill current EX instruction (branch/jump redirect).
- ALUOp  in  2  controller opcode class; 2'b10 = R-type.
- Funct7  in  7  instruction bits 31:25.
- Funct3  in  3  instruction bits 14:12.
- SrcA  in  XLEN  rs1 operand.
- SrcB  in  XLEN  rs2 operand.
- is_m_op  out  1  combinational: in_valid && ALUOp==2'b10 && Funct7==7'b0000001.
- stall  out  1  combinational: is_m_op && state!=DONE && !flush.
- done  out  1  high exactly one cycle (DONE state); result valid.
- result  out  XLEN  registered result; holds last value until next accept.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, done=0, result=0, counter/accumulators=0. Reset mid-operation aborts with no done pulse.
- States are IDLE, CALC, DONE.
- IDLE → CALC when is_m_op && !flush ("accept" edge):
  - Latch the op (Funct3).
  - Latch the sign flags of A and B, per op signedness.
  - Latch the absolute-value operands.
  - Load counter=ITER.
- IDLE → DONE directly on accept for the special cases:
  - DIV/DIVU/REM/REMU with SrcB==0: quotient = all ones; remainder = SrcA.
  - DIV/REM with SrcA==1<<(XLEN-1) and SrcB==all ones: quotient = SrcA; remainder = 0.
  - result is registered at that edge.
- CALC, every cycle:
  - Process UNROLL bits.
  - Multiplier: 2·XLEN product register, LSB-first shift-add.
  - Divider: restoring, MSB-first; partial remainder is XLEN+1 bits.
  - Decrement the counter.
  - When counter reaches 1, the next edge goes CALC → DONE and writes result.
- Result sign correction is applied on that CALC→DONE edge:
  - MUL/MULH: negate the 2·XLEN product if signA^signB.
  - MULHSU: negate if signA (SrcB is unsigned).
  - DIV: negate quotient if signA^signB.
  - REM: remainder takes signA.
- Result selection:
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits.
  - Unsigned ops never negate.
- DONE → IDLE unconditionally next edge. The pipeline advances on the DONE cycle because stall is low.
- Latency (UNROLL=1, XLEN=32):
  - done is high in the 33rd cycle after the accept edge.
  - stall is high for 33 cycles: the accept cycle plus 32 CALC cycles.
  - Special cases: done in the cycle after accept; stall high 1 cycle.
- Non-M instructions: is_m_op=0, stall=0, and the state machine stays in IDLE.
- Back-to-back M ops: the second is accepted in the IDLE cycle after DONE, with no lost cycle beyond the DONE→IDLE step.
- flush in CALC: next state IDLE, no done pulse, result unchanged.
- flush in DONE: done still pulses and the state still returns to IDLE; the pipeline discards the result.
- Operands are latched at accept. Changes on SrcA/SrcB during CALC are ignored.

Decomposition:
- Package rv_muldiv_pkg:
  - md_op_e enum of Funct3 encodings: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - state_e {IDLE, CALC, DONE}.
  - FUNCT7_MEXT=7'b0000001 and ALUOP_RTYPE=2'b10 constants.
- One natural sub-module: rv_muldiv_step, a combinational UNROLL-bit multiply/divide iteration, instantiated once.

Test Plan:
- MUL SrcA=7, SrcB=0xFFFFFFFD → result 0xFFFFFFEB, done 33 cycles after accept, stall high exactly 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
  - Each completes with done one cycle after accept.
- flush asserted 10 cycles into a DIV → no done pulse, result unchanged, state IDLE. A following MUL 3×4 → 12.
- reset asserted mid-CALC (asynchronous, between edges) → done=0, result=0, stall=0 immediately. ADD (Funct7=0) → is_m_op=0, stall=0 throughout.
